// File: rtl/router_arbiter.sv
// router_arbiter: four-requester, packet-aware round-robin arbiter feeding a shared
// 1-to-4 router datapath.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   req_valid[4]     beat valid per requester
//   req_data         beat data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_addr[8]      destination port, requester i at [2*i +: 2]
//   req_last[4]      final beat of packet per requester
//   req_ready[4]     combinational accept, one-hot or zero
//   dest_ready[4]    router output port p can accept a beat
//   router_din       registered beat data to router
//   router_din_en    registered beat strobe
//   router_addr      registered destination port
//   grant_cnt[64]    per-requester packet counters (only with ROUTER_ARB_STATS_EN)
//
// Optional feature macro: ROUTER_ARB_STATS_EN adds saturating 16-bit packet counters.

module router_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [3:0]              req_valid,
  input  logic [4*DATA_WIDTH-1:0] req_data,
  input  logic [7:0]              req_addr,
  input  logic [3:0]              req_last,
  output logic [3:0]              req_ready,
  input  logic [3:0]              dest_ready,
  output logic [DATA_WIDTH-1:0]   router_din,
  output logic                    router_din_en,
  output logic [1:0]              router_addr
`ifdef ROUTER_ARB_STATS_EN
  ,
  output logic [63:0]             grant_cnt
`endif
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] lock_addr_q, lock_addr_d;

  logic [3:0] eligible;
  logic [1:0] sel;
  logic [1:0] dest_addr;
  logic       found;
  logic       xfer;
  logic       first_beat;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eligible[i] = req_valid[i] && dest_ready[req_addr[2*i +: 2]];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    lock_addr_d = lock_addr_q;
    req_ready   = '0;
    sel         = '0;
    found       = 1'b0;
    xfer        = 1'b0;
    first_beat  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Scan from rr_ptr with 2-bit wraparound; first eligible requester wins.
        for (int k = 0; k < 4; k++) begin
          logic [1:0] idx;
          idx = rr_ptr_q + 2'(k);
          if (!found && eligible[idx]) begin
            found = 1'b1;
            sel   = idx;
          end
        end
        if (found) begin
          req_ready  = 4'b0001 << sel;
          xfer       = 1'b1;
          first_beat = 1'b1;
          rr_ptr_d   = sel + 2'd1;
          if (!req_last[sel]) begin
            state_d     = StBusy;
            owner_d     = sel;
            lock_addr_d = req_addr[2*sel +: 2];
          end
        end
      end
      StBusy: begin
        sel            = owner_q;
        req_ready[sel] = dest_ready[lock_addr_q];
        xfer           = req_valid[sel] && dest_ready[lock_addr_q];
        if (xfer && req_last[sel]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Owner's live req_addr is ignored once the packet is locked.
  assign dest_addr = (state_q == StBusy) ? lock_addr_q : req_addr[2*sel +: 2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      lock_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      lock_addr_q <= lock_addr_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      router_din    <= '0;
      router_din_en <= 1'b0;
      router_addr   <= '0;
    end else begin
      router_din_en <= xfer;
      if (xfer) begin
        router_din  <= req_data[sel*DATA_WIDTH +: DATA_WIDTH];
        router_addr <= dest_addr;
      end
    end
  end

`ifdef ROUTER_ARB_STATS_EN
  logic [15:0] cnt_q [4];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (first_beat && (sel == 2'(i)) && (cnt_q[i] != 16'hFFFF)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
  logic unused_first_beat;
  assign unused_first_beat = first_beat;
`endif

endmodule

// File: tb/tb_router_arbiter.sv
// Self-checking bench for router_arbiter: directed vectors with literal expectations,
// plus a transaction-level model compared against the DUT on every cycle out of reset.

module tb_router_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [3:0]    req_valid = '0;
  logic [4*DW-1:0] req_data = '0;
  logic [7:0]    req_addr = '0;
  logic [3:0]    req_last = '0;
  logic [3:0]    req_ready;
  logic [3:0]    dest_ready = 4'hF;
  logic [DW-1:0] router_din;
  logic          router_din_en;
  logic [1:0]    router_addr;
`ifdef ROUTER_ARB_STATS_EN
  logic [63:0]   grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_addr      (req_addr),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .dest_ready    (dest_ready),
    .router_din    (router_din),
    .router_din_en (router_din_en),
    .router_addr   (router_addr)
`ifdef ROUTER_ARB_STATS_EN
    ,
    .grant_cnt     (grant_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model ----------------
  // Packet owner is -1 when no packet is in flight.
  int          m_owner = -1;
  int          m_lock = 0;
  int          m_rr = 0;
  logic [31:0] m_din = '0;
  logic [1:0]  m_addr = '0;
  logic        m_en = 1'b0;
  int          m_pkts [4] = '{0, 0, 0, 0};

  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    int         i;
    r = '0;
    if (m_owner >= 0) begin
      r[m_owner] = dest_ready[m_lock];
    end else begin
      for (int k = 0; k < 4; k++) begin
        i = (m_rr + k) % 4;
        if (r == 4'b0 && req_valid[i] && dest_ready[req_addr[2*i +: 2]]) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin : model_upd
    logic [3:0] r;
    if (!resetn) begin
      m_owner <= -1;
      m_lock  <= 0;
      m_rr    <= 0;
      m_din   <= '0;
      m_addr  <= '0;
      m_en    <= 1'b0;
      for (int i = 0; i < 4; i++) m_pkts[i] <= 0;
    end else begin
      r = model_ready();
      m_en <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && r[i]) begin
          m_en  <= 1'b1;
          m_din <= req_data[i*DW +: DW];
          if (m_owner >= 0) begin
            m_addr <= 2'(m_lock);
            if (req_last[i]) m_owner <= -1;
          end else begin
            m_addr    <= req_addr[2*i +: 2];
            m_rr      <= (i + 1) % 4;
            m_pkts[i] <= m_pkts[i] + 1;
            if (!req_last[i]) begin
              m_owner <= i;
              m_lock  <= int'(req_addr[2*i +: 2]);
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (resetn) begin
      chk("m_req_ready", 64'(req_ready), 64'(model_ready()));
      chk("m_din_en", 64'(router_din_en), 64'(m_en));
      chk("m_din", 64'(router_din), 64'(m_din));
      chk("m_addr", 64'(router_addr), 64'(m_addr));
`ifdef ROUTER_ARB_STATS_EN
      begin
        logic [63:0] e;
        for (int i = 0; i < 4; i++) begin
          e[16*i +: 16] = (m_pkts[i] > 65535) ? 16'hFFFF : 16'(m_pkts[i]);
        end
        chk("m_grant_cnt", grant_cnt, e);
      end
`endif
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] a,
                         input logic [31:0] d, input logic l);
    req_valid[i]         = v;
    req_addr[2*i +: 2]   = a;
    req_data[i*DW +: DW] = d;
    req_last[i]          = l;
  endtask

  task automatic clr_all();
    req_valid  = '0;
    req_last   = '0;
    dest_ready = 4'hF;
  endtask

  task automatic apply_reset();
    clr_all();
    resetn = 1'b0;
    #1;
    chk("rst_din_en", 64'(router_din_en), 64'd0);
    chk("rst_din", 64'(router_din), 64'd0);
    chk("rst_addr", 64'(router_addr), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Single beat
    apply_reset();
    set_req(2, 1, 2'd3, 32'hA5A5_0001, 1);
    @(negedge clk); chk("t1_ready", 64'(req_ready), 64'b0100);
    cyc(); clr_all();
    @(negedge clk);
    chk("t1_din", 64'(router_din), 64'hA5A5_0001);
    chk("t1_addr", 64'(router_addr), 64'd3);
    chk("t1_en", 64'(router_din_en), 64'd1);
    cyc();
    @(negedge clk); chk("t1_en_off", 64'(router_din_en), 64'd0);

    // Round robin: 0,1,2,3,0
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1, 2'(i), 32'h100 + i, 1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); chk("t2_grant", 64'(req_ready), 64'(4'b0001 << (n % 4)));
      cyc();
    end
    clr_all();

    // Packet lock: rr_ptr is now 1
    set_req(0, 1, 2'd2, 32'h300, 1);
    set_req(2, 1, 2'd3, 32'h302, 1);
    set_req(1, 1, 2'd0, 32'hB1, 0);
    @(negedge clk); chk("t3_b1_ready", 64'(req_ready), 64'b0010);
    cyc(); set_req(1, 1, 2'd3, 32'hB2, 0);
    @(negedge clk);
    chk("t3_b2_ready", 64'(req_ready), 64'b0010);
    chk("t3_b1_din", 64'(router_din), 64'hB1);
    chk("t3_b1_addr", 64'(router_addr), 64'd0);
    cyc(); set_req(1, 1, 2'd3, 32'hB3, 1);
    @(negedge clk);
    chk("t3_b3_ready", 64'(req_ready), 64'b0010);
    chk("t3_b2_din", 64'(router_din), 64'hB2);
    chk("t3_b2_addr", 64'(router_addr), 64'd0);
    cyc(); req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t3_next_ready", 64'(req_ready), 64'b0100);
    chk("t3_b3_din", 64'(router_din), 64'hB3);
    chk("t3_b3_addr", 64'(router_addr), 64'd0);
    cyc(); clr_all();

    // Backpressure
    apply_reset();
    dest_ready = 4'b1101;
    set_req(0, 1, 2'd1, 32'h400, 1);
    set_req(3, 1, 2'd2, 32'hC1, 0);
    @(negedge clk); chk("t4_ready", 64'(req_ready), 64'b1000);
    cyc(); req_valid[0] = 1'b0; set_req(3, 1, 2'd2, 32'hC2, 1); dest_ready = 4'b1001;
    @(negedge clk);
    chk("t4_stall1_ready", 64'(req_ready), 64'd0);
    chk("t4_c1_en", 64'(router_din_en), 64'd1);
    chk("t4_c1_din", 64'(router_din), 64'hC1);
    chk("t4_c1_addr", 64'(router_addr), 64'd2);
    cyc();
    @(negedge clk);
    chk("t4_stall2_ready", 64'(req_ready), 64'd0);
    chk("t4_stall_en", 64'(router_din_en), 64'd0);
    chk("t4_hold_din", 64'(router_din), 64'hC1);
    cyc(); dest_ready = 4'hF;
    @(negedge clk);
    chk("t4_resume_ready", 64'(req_ready), 64'b1000);
    chk("t4_stall_en2", 64'(router_din_en), 64'd0);
    cyc(); clr_all();
    @(negedge clk);
    chk("t4_c2_en", 64'(router_din_en), 64'd1);
    chk("t4_c2_din", 64'(router_din), 64'hC2);

    // Reset mid-packet
    apply_reset();
    set_req(1, 1, 2'd0, 32'hD1, 0);
    @(negedge clk); chk("t5_ready", 64'(req_ready), 64'b0010);
    cyc(); set_req(1, 1, 2'd0, 32'hD2, 0); set_req(0, 1, 2'd1, 32'h500, 1);
    @(negedge clk); chk("t5_d1_din", 64'(router_din), 64'hD1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_async_en", 64'(router_din_en), 64'd0);
    chk("t5_async_din", 64'(router_din), 64'd0);
    chk("t5_async_addr", 64'(router_addr), 64'd0);
    @(posedge clk);
    #2 resetn = 1'b1;
    @(negedge clk); chk("t5_after_ready", 64'(req_ready), 64'b0001);
    cyc(); clr_all();
    @(negedge clk);
    chk("t5_after_din", 64'(router_din), 64'h500);
    chk("t5_after_addr", 64'(router_addr), 64'd1);

`ifdef ROUTER_ARB_STATS_EN
    apply_reset();
    set_req(0, 1, 2'd0, 32'h600, 1);
    repeat (70000) @(posedge clk);
    #1 clr_all();
    @(negedge clk); chk("t6_grant_cnt", grant_cnt, 64'h0000_0000_0000_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_arbiter.md
# router_arbiter

Four-requester, packet-aware round-robin arbiter that sequences the shared 1-to-4 router datapath. It accepts beats from four upstream requesters over valid/ready, admits a requester only when its destination port can accept, holds the grant for multi-beat packets, and drives registered `din`/`din_en`/`addr` into the router. Downstream per-port readiness (`dest_ready`) provides backpressure.

## Interface
- `DATA_WIDTH`, 32, width of one data beat.
- `clk`  in  1  single clock; all state on rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `req_valid`  in  4  beat valid per requester i.
- `req_data`  in  4*DATA_WIDTH  beat data; requester i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_addr`  in  8  destination port per requester; requester i at `[2*i +: 2]`.
- `req_last`  in  4  final beat of packet per requester.
- `req_ready`  out  4  beat accepted when `req_valid[i] && req_ready[i]`; combinational, one-hot or zero.
- `dest_ready`  in  4  router output port p can accept a beat this cycle.
- `router_din`  out  DATA_WIDTH  registered beat to router.
- `router_din_en`  out  1  registered beat strobe.
- `router_addr`  out  2  registered destination port.

## Operation
- States: IDLE (no owner), BUSY (packet in flight, `owner` and `lock_addr` held).
- Eligible in IDLE: `req_valid[i] && dest_ready[req_addr[i]]`.
- IDLE: search eligible requesters starting at `rr_ptr`, wrapping 3->0; winner w gets `req_ready[w]=1`. On transfer: `rr_ptr <= (w+1) mod 4`; if `req_last[w]=0` go BUSY with `owner=w`, `lock_addr=req_addr[w]`; else stay IDLE (single-beat packet).
- BUSY: only owner may transfer; `req_ready[owner] = dest_ready[lock_addr]`; other `req_ready` bits 0. Owner's `req_addr` ignored; `lock_addr` used. Transfer with `req_last=1` returns to IDLE; `rr_ptr` unchanged in BUSY.
- Owner dropping `req_valid` mid-packet: stall, remain BUSY, no timeout.
- Per transfer: next cycle `router_din`=beat data, `router_addr`=destination, `router_din_en`=1. No transfer: `router_din_en`=0, `router_din`/`router_addr` hold last values.
- No eligible requester in IDLE: all `req_ready`=0, state unchanged.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `rr_ptr`=0, `owner`=0, `lock_addr`=0, `router_din`=0, `router_din_en`=0, `router_addr`=0, `req_ready`=0; stats counters 0.
- Latency: handshake in cycle N -> `router_din_en`=1 in cycle N+1. Throughput one beat/cycle, including back-to-back packets from different requesters (IDLE->grant in same cycle as previous `last`).
- `req_ready` depends combinationally on `req_valid`, `req_addr`, `dest_ready` and state; no combinational path to router outputs.
- Reset mid-packet: packet abandoned, returns to IDLE; `router_din_en` drops immediately.

## Configuration
- `ROUTER_ARB_STATS_EN` defined: adds output `grant_cnt` (4x16 = 64 bits, requester i at `[16*i +: 16]`), incremented on each packet's first beat, saturating at 16'hFFFF, reset to 0.
- Not defined: port and counters absent; behaviour otherwise identical.

## Test plan
- Single beat: reset, req 2 valid, addr 3, data 0xA5A5_0001, last=1, dest_ready=4'hF -> `req_ready`=4'b0100 same cycle; next cycle `router_din`=0xA5A5_0001, `router_addr`=3, `router_din_en`=1.
- Round robin: all four valid single-beat, dest_ready=4'hF -> grants in order 0,1,2,3,0 over five cycles.
- Packet lock: req 1 sends 3-beat packet to port 0 while req 0 and 2 valid -> only req 1 granted for 3 beats, then req 2 (rr_ptr=2) granted.
- Backpressure: req 0 to port 1 with `dest_ready[1]`=0, req 3 to port 2 ready -> req 3 granted; mid-packet `dest_ready[lock_addr]`=0 for 2 cycles -> `router_din_en`=0 for those cycles, no beat lost.
- Reset mid-packet: assert `resetn`=0 during beat 2 of 4 -> outputs zero asynchronously; after release, lowest-index eligible requester from rr_ptr=0 granted.
- Stats (with macro): 70000 single-beat packets from req 0 -> `grant_cnt[15:0]`=16'hFFFF, others 0.
